// File: rtl/pc_fetch_gen.sv
// Program-counter generator: holds the virtual PC, steps/redirects/stalls it,
// and freezes fetch in a fault state with the offending PC latched in EPC.
module pc_fetch_gen #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter logic [31:0] HANDLER_PC = 32'h0040_0180,
   parameter logic [31:0] PC_STEP    = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        STALL,
   input  logic        REDIRECT,
   input  logic [31:0] TARGET,
   input  logic        IPC,
   input  logic        FAULT_CLR,
   output logic [31:0] VPC,
   output logic        FETCH_VALID,
   output logic        FAULT,
   output logic [31:0] EPC,
   output logic [31:0] FETCH_CNT
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'b00,
      S_RUN   = 2'b01,
      S_FAULT = 2'b10
   } state_t;

   state_t state;
   logic   bad;

   // IPC is the decoder's verdict on the current VPC, so validity is combinational.
   assign bad         = IPC | (VPC[1:0] != 2'b00);
   assign FETCH_VALID = (state == S_RUN) & ~bad;
   assign FAULT       = (state == S_FAULT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_BOOT;
         VPC       <= RESET_PC;
         EPC       <= '0;
         FETCH_CNT <= '0;
      end else begin
         case (state)
            S_BOOT: state <= S_RUN;
            S_RUN: begin
               if (bad) begin
                  state <= S_FAULT;
                  EPC   <= VPC;
               end else if (REDIRECT) begin
                  VPC <= TARGET;
               end else if (!STALL) begin
                  VPC       <= VPC + PC_STEP;
                  FETCH_CNT <= FETCH_CNT + 32'd1;
               end
            end
            S_FAULT: begin
               if (FAULT_CLR) begin
                  state <= S_RUN;
                  VPC   <= HANDLER_PC;
               end
            end
            default: state <= S_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Scoreboard bench for pc_fetch_gen: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_pc_fetch_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        STALL = 1'b0;
   logic        REDIRECT = 1'b0;
   logic [31:0] TARGET = '0;
   logic        IPC = 1'b0;
   logic        FAULT_CLR = 1'b0;
   logic [31:0] VPC;
   logic        FETCH_VALID;
   logic        FAULT;
   logic [31:0] EPC;
   logic [31:0] FETCH_CNT;

   typedef struct {
      logic [31:0] vpc;
      logic        fv;
      logic        flt;
      logic [31:0] epc;
      logic [31:0] cnt;
      int          tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   tag_n  = 0;

   pc_fetch_gen #(
      .RESET_PC  (32'h0040_0000),
      .HANDLER_PC(32'h0040_0180),
      .PC_STEP   (32'd4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .STALL      (STALL),
      .REDIRECT   (REDIRECT),
      .TARGET     (TARGET),
      .IPC        (IPC),
      .FAULT_CLR  (FAULT_CLR),
      .VPC        (VPC),
      .FETCH_VALID(FETCH_VALID),
      .FAULT      (FAULT),
      .EPC        (EPC),
      .FETCH_CNT  (FETCH_CNT)
   );

   always #5 clk = ~clk;

   task automatic expect_now(input logic [31:0] vpc, input logic fv, input logic flt,
                             input logic [31:0] epc, input logic [31:0] cnt);
      exp_t e;
      e.vpc = vpc; e.fv = fv; e.flt = flt; e.epc = epc; e.cnt = cnt; e.tag = tag_n;
      tag_n++;
      sb.push_back(e);
   endtask

   // Called at posedge+1: drive this cycle's inputs, queue the outputs expected
   // before the next edge, then advance to the next posedge+1.
   task automatic step(input logic s, input logic r, input logic [31:0] t, input logic ipc,
                       input logic clr, input logic [31:0] vpc, input logic fv, input logic flt,
                       input logic [31:0] epc, input logic [31:0] cnt);
      STALL = s; REDIRECT = r; TARGET = t; IPC = ipc; FAULT_CLR = clr;
      expect_now(vpc, fv, flt, epc, cnt);
      @(posedge clk); #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (VPC !== e.vpc || FETCH_VALID !== e.fv || FAULT !== e.flt ||
                EPC !== e.epc || FETCH_CNT !== e.cnt) begin
               errors++;
               $display("FAIL step%0d: vpc=%h/%h fv=%b/%b fault=%b/%b epc=%h/%h cnt=%0d/%0d (got/exp)",
                        e.tag, VPC, e.vpc, FETCH_VALID, e.fv, FAULT, e.flt, EPC, e.epc,
                        FETCH_CNT, e.cnt);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL timeout: sim time exceeded, pending=%0d required=0", sb.size());
      $fatal(1, "timeout");
   end

   initial begin : stim
      @(posedge clk); #1;
      // held in reset
      step(0, 0, '0, 0, 0, 32'h0040_0000, 0, 0, '0, 0);
      rst_n = 1'b1;
      // BOOT, then three free-running fetches
      step(0, 0, '0, 0, 0, 32'h0040_0000, 0, 0, '0, 0);
      step(0, 0, '0, 0, 0, 32'h0040_0000, 1, 0, '0, 0);
      step(0, 0, '0, 0, 0, 32'h0040_0004, 1, 0, '0, 1);
      // stall two cycles at 0x400008
      step(1, 0, '0, 0, 0, 32'h0040_0008, 1, 0, '0, 2);
      step(1, 0, '0, 0, 0, 32'h0040_0008, 1, 0, '0, 2);
      // redirect wins over stall
      step(1, 1, 32'h0040_0100, 0, 0, 32'h0040_0008, 1, 0, '0, 2);
      step(0, 1, 32'h0040_0102, 0, 0, 32'h0040_0100, 1, 0, '0, 2);
      // misaligned target loaded, faults on the following edge
      step(0, 0, '0, 0, 0, 32'h0040_0102, 0, 0, '0, 2);
      // inputs ignored while in FAULT
      for (int i = 0; i < 10; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              1'($urandom_range(0, 1)), 0, 32'h0040_0102, 0, 1, 32'h0040_0102, 2);
      step(0, 1, 32'h1234_5678, 0, 1, 32'h0040_0102, 0, 1, 32'h0040_0102, 2);
      // handler entry, then redirect to run across 0x401000
      step(0, 1, 32'h0040_0FF8, 0, 0, 32'h0040_0180, 1, 0, 32'h0040_0102, 2);
      step(0, 0, '0, 0, 0, 32'h0040_0FF8, 1, 0, 32'h0040_0102, 2);
      step(0, 0, '0, 0, 0, 32'h0040_0FFC, 1, 0, 32'h0040_0102, 3);
      step(0, 0, '0, 0, 0, 32'h0040_1000, 1, 0, 32'h0040_0102, 4);
      // decoder flags 0x401004 invalid
      step(0, 0, '0, 1, 0, 32'h0040_1004, 0, 0, 32'h0040_0102, 5);
      step(0, 1, 32'h0000_0040, 1, 0, 32'h0040_1004, 0, 1, 32'h0040_1004, 5);
      step(1, 0, '0, 1, 0, 32'h0040_1004, 0, 1, 32'h0040_1004, 5);
      step(0, 0, '0, 0, 1, 32'h0040_1004, 0, 1, 32'h0040_1004, 5);
      // FAULT_CLR outside FAULT has no effect
      step(0, 0, '0, 0, 1, 32'h0040_0180, 1, 0, 32'h0040_1004, 5);
      step(0, 0, '0, 0, 0, 32'h0040_0184, 1, 0, 32'h0040_1004, 6);
      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      expect_now(32'h0040_0000, 0, 0, '0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(0, 0, '0, 0, 0, 32'h0040_0000, 0, 0, '0, 0);
      step(0, 0, '0, 0, 0, 32'h0040_0000, 1, 0, '0, 0);
      // PC wrap past 2^32
      step(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0040_0004, 1, 0, '0, 1);
      step(0, 0, '0, 0, 0, 32'hFFFF_FFFC, 1, 0, '0, 1);
      step(0, 0, '0, 0, 0, 32'h0000_0000, 1, 0, '0, 2);
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
